// File: rtl/ntt_defines_pkg.sv
// Shared types and timing constants for the masked NTT/PWM datapath.
// Imported by the PWM sequencer and its valid pipe.
package ntt_defines_pkg;

    typedef enum logic [1:0] {
        PWM_IDLE,
        PWM_ISSUE,
        PWM_DRAIN,
        PWM_DONE
    } pwm_seq_state_e;

    localparam int MLKEM_PWM_LAT_ACC     = 24;
    localparam int MLKEM_PWM_LAT_NOACC   = 23;
    localparam int MLKEM_PWM_W_RD_OFFSET = 16;

endpackage

// File: rtl/ntt_pwm_valid_pipe.sv
// Valid shift register tracking beats inside the fixed-latency PWM datapath.
// Write tap is runtime selectable; w-read tap is fixed at elaboration.
module ntt_pwm_valid_pipe
    import ntt_defines_pkg::*;
#(
    parameter int DEPTH = MLKEM_PWM_LAT_ACC + 1,
    parameter int W_TAP = MLKEM_PWM_W_RD_OFFSET - 1,
    parameter int TAP_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             din_i,
    input  logic [TAP_W-1:0] wr_tap_i,
    output logic             wr_o,
    output logic             w_o,
    output logic             pending_o
);

    logic [DEPTH-1:0] pipe_q;
    logic [DEPTH-1:0] pipe_d;

    // Shift a new beat in each cycle; clear drops everything in flight.
    always_comb begin
        pipe_d = {pipe_q[DEPTH-2:0], din_i};
        if (clear_i) begin
            pipe_d = '0;
        end
    end

    // Pipe register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign wr_o = pipe_q[wr_tap_i];
    assign w_o  = pipe_q[W_TAP];

    // Beats not yet at the write tap; bits past the tap are spent.
    always_comb begin
        pending_o = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (k < int'(wr_tap_i)) begin
                pending_o = pending_o | pipe_q[k];
            end
        end
    end

endmodule

// File: rtl/ntt_masked_pwm_sequencer.sv
// Sequencer for the masked pairwise-multiply datapath over one polynomial.
// Optional NTT_MASKED_PWM_SEQ_STATS_EN adds a randomness-stall counter.
module ntt_masked_pwm_sequencer
    import ntt_defines_pkg::*;
#(
    parameter int NUM_PAIRS   = 128,
    parameter int ADDR_WIDTH  = 7,
    parameter int LAT_ACC     = MLKEM_PWM_LAT_ACC,
    parameter int LAT_NOACC   = MLKEM_PWM_LAT_NOACC,
    parameter int W_RD_OFFSET = MLKEM_PWM_W_RD_OFFSET
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  zeroize,
    input  logic                  start,
    input  logic                  accumulate_mode,
    input  logic [ADDR_WIDTH-1:0] src_base,
    input  logic [ADDR_WIDTH-1:0] dst_base,
    input  logic                  rnd_valid,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [ADDR_WIDTH-1:0] zeta_idx,
    output logic                  w_rd_en,
    output logic [ADDR_WIDTH-1:0] w_rd_addr,
    output logic                  accumulate,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic                  busy,
`ifdef NTT_MASKED_PWM_SEQ_STATS_EN
    output logic [15:0]           stall_cnt,
`endif
    output logic                  done
);

    localparam int DEPTH = LAT_ACC + 1;
    localparam int TAP_W = $clog2(DEPTH);
    localparam int CW    = ADDR_WIDTH + 1;

    pwm_seq_state_e state_q, state_d;

    logic                  acc_q, acc_d;
    logic [ADDR_WIDTH-1:0] src_q, src_d;
    logic [ADDR_WIDTH-1:0] dst_q, dst_d;
    logic [TAP_W-1:0]      lat_q, lat_d;
    logic [ADDR_WIDTH-1:0] iss_q, iss_d;
    logic [CW-1:0]         wcnt_q, wcnt_d;
    logic [ADDR_WIDTH-1:0] wrd_q, wrd_d;

    logic start_ok;
    logic tap_wr;
    logic tap_w;
    logic pending;
    logic [CW-1:0] wcnt_nxt;

    assign start_ok = (state_q == PWM_IDLE) && start && !zeroize;

    assign wr_en   = tap_wr && !zeroize;
    assign w_rd_en = tap_w && acc_q && !zeroize;

    assign wcnt_nxt = wcnt_q + CW'(wr_en);

    // FSM next state and state-decoded strobes.
    always_comb begin
        state_d = state_q;
        rd_en   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            PWM_IDLE: begin
                if (start_ok) begin
                    state_d = PWM_ISSUE;
                end
            end
            PWM_ISSUE: begin
                busy  = 1'b1;
                rd_en = rnd_valid && !zeroize;
                if (rd_en && iss_q == ADDR_WIDTH'(NUM_PAIRS - 1)) begin
                    state_d = PWM_DRAIN;
                end
            end
            PWM_DRAIN: begin
                busy = 1'b1;
                if (wcnt_nxt == CW'(NUM_PAIRS) && !pending) begin
                    state_d = PWM_DONE;
                end
            end
            PWM_DONE: begin
                done    = 1'b1;
                state_d = PWM_IDLE;
            end
            default: begin
                state_d = PWM_IDLE;
            end
        endcase
        if (zeroize) begin
            state_d = PWM_IDLE;
        end
    end

    // Operation context and beat counters.
    always_comb begin
        acc_d  = acc_q;
        src_d  = src_q;
        dst_d  = dst_q;
        lat_d  = lat_q;
        iss_d  = iss_q;
        wcnt_d = wcnt_nxt;
        wrd_d  = wrd_q;
        if (rd_en) begin
            iss_d = iss_q + ADDR_WIDTH'(1);
        end
        if (w_rd_en) begin
            wrd_d = wrd_q + ADDR_WIDTH'(1);
        end
        if (start_ok) begin
            acc_d  = accumulate_mode;
            src_d  = src_base;
            dst_d  = dst_base;
            lat_d  = accumulate_mode ? TAP_W'(LAT_ACC) : TAP_W'(LAT_NOACC);
            iss_d  = '0;
            wcnt_d = '0;
            wrd_d  = '0;
        end
        if (zeroize) begin
            acc_d  = 1'b0;
            src_d  = '0;
            dst_d  = '0;
            lat_d  = '0;
            iss_d  = '0;
            wcnt_d = '0;
            wrd_d  = '0;
        end
    end

    // State and context registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= PWM_IDLE;
            acc_q   <= 1'b0;
            src_q   <= '0;
            dst_q   <= '0;
            lat_q   <= '0;
            iss_q   <= '0;
            wcnt_q  <= '0;
            wrd_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            lat_q   <= lat_d;
            iss_q   <= iss_d;
            wcnt_q  <= wcnt_d;
            wrd_q   <= wrd_d;
        end
    end

    ntt_pwm_valid_pipe #(
        .DEPTH (DEPTH),
        .W_TAP (W_RD_OFFSET - 1),
        .TAP_W (TAP_W)
    ) u_pipe (
        .clk       (clk),
        .rst       (reset),
        .clear_i   (zeroize),
        .din_i     (rd_en),
        .wr_tap_i  (lat_q),
        .wr_o      (tap_wr),
        .w_o       (tap_w),
        .pending_o (pending)
    );

    assign accumulate = acc_q;
    assign rd_addr    = src_q + iss_q;
    assign zeta_idx   = iss_q;
    assign w_rd_addr  = dst_q + wrd_q;
    assign wr_addr    = dst_q + wcnt_q[ADDR_WIDTH-1:0];

`ifdef NTT_MASKED_PWM_SEQ_STATS_EN
    logic [15:0] stall_q, stall_d;

    // Saturating count of ISSUE cycles starved of randomness.
    always_comb begin
        stall_d = stall_q;
        if (zeroize || start_ok) begin
            stall_d = '0;
        end else if (state_q == PWM_ISSUE && !rnd_valid &&
                     stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_ntt_masked_pwm_sequencer.sv
// Directed self-checking bench for ntt_masked_pwm_sequencer.
// Stall counter checks compile in with NTT_MASKED_PWM_SEQ_STATS_EN.
module tb_ntt_masked_pwm_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       zeroize = 1'b0;
    logic       start = 1'b0;
    logic       accumulate_mode = 1'b0;
    logic [6:0] src_base = '0;
    logic [6:0] dst_base = '0;
    logic       rnd_valid = 1'b0;
    logic       rd_en, w_rd_en, accumulate, wr_en, busy, done;
    logic [6:0] rd_addr, zeta_idx, w_rd_addr, wr_addr;
`ifdef NTT_MASKED_PWM_SEQ_STATS_EN
    logic [15:0] stall_cnt;
`endif

    ntt_masked_pwm_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .zeroize         (zeroize),
        .start           (start),
        .accumulate_mode (accumulate_mode),
        .src_base        (src_base),
        .dst_base        (dst_base),
        .rnd_valid       (rnd_valid),
        .rd_en           (rd_en),
        .rd_addr         (rd_addr),
        .zeta_idx        (zeta_idx),
        .w_rd_en         (w_rd_en),
        .w_rd_addr       (w_rd_addr),
        .accumulate      (accumulate),
        .wr_en           (wr_en),
        .wr_addr         (wr_addr),
        .busy            (busy),
`ifdef NTT_MASKED_PWM_SEQ_STATS_EN
        .stall_cnt       (stall_cnt),
`endif
        .done            (done)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Monitor state, sampled on the falling edge.
    logic       mon_clr = 1'b0;
    logic       exp_acc = 1'b0;
    logic       pat_en = 1'b0;
    int         cyc = 0;
    int         n_rd, n_wr, n_w, n_done;
    int         first_rd, first_wr, first_w;
    int         last_wr_cyc, done_cyc, first_wr_addr, last_wr_addr;
    int         busy_at_done, rd_err, wr_err, w_err, acc_err, pat_err;
    logic [6:0] exp_rd, exp_wr, exp_w, exp_z;
    bit [63:0]  rd_hist = '0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        rd_hist[cyc % 64] = rd_en;
        if (mon_clr) begin
            n_rd = 0; n_wr = 0; n_w = 0; n_done = 0;
            first_rd = -1; first_wr = -1; first_w = -1;
            last_wr_cyc = -1; done_cyc = -1;
            first_wr_addr = -1; last_wr_addr = -1; busy_at_done = -1;
            rd_err = 0; wr_err = 0; w_err = 0; acc_err = 0; pat_err = 0;
            exp_rd = src_base; exp_wr = dst_base; exp_w = dst_base;
            exp_z = '0;
        end else begin
            if (rd_en) begin
                if (first_rd < 0) first_rd = cyc;
                if (rd_addr !== exp_rd || zeta_idx !== exp_z) rd_err++;
                exp_rd = exp_rd + 7'd1;
                exp_z  = exp_z + 7'd1;
                n_rd++;
            end
            if (wr_en) begin
                if (first_wr < 0) begin
                    first_wr = cyc;
                    first_wr_addr = int'(wr_addr);
                end
                if (wr_addr !== exp_wr) wr_err++;
                exp_wr = exp_wr + 7'd1;
                last_wr_cyc = cyc;
                last_wr_addr = int'(wr_addr);
                n_wr++;
            end
            if (w_rd_en) begin
                if (first_w < 0) first_w = cyc;
                if (w_rd_addr !== exp_w) w_err++;
                exp_w = exp_w + 7'd1;
                n_w++;
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
                busy_at_done = int'(busy);
            end
            if (busy && accumulate !== exp_acc) acc_err++;
            if (pat_en && wr_en !== rd_hist[(cyc - 24) % 64]) pat_err++;
        end
    end

    task automatic op(input logic acc, input logic [6:0] s,
                      input logic [6:0] d, input bit bub,
                      input int zk, input int sk, input int ncyc);
        accumulate_mode = acc;
        src_base = s;
        dst_base = d;
        exp_acc = acc;
        pat_en = !acc;
        mon_clr = 1'b1;
        start = 1'b1;
        rnd_valid = 1'b1;
        @(posedge clk); #1;
        mon_clr = 1'b0;
        start = 1'b0;
        accumulate_mode = ~acc;
        src_base = ~s;
        dst_base = ~d;
        for (int k = 0; k < ncyc; k++) begin
            rnd_valid = bub ? ((k % 4) != 3) : 1'b1;
            zeroize = (k == zk);
            start = (k == sk);
            @(posedge clk); #1;
        end
        zeroize = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd_en", int'(rd_en), 0);
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_acc", int'(accumulate), 0);
        chk("rst_wr_addr", int'(wr_addr), 0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        op(1'b0, 7'h00, 7'h40, 1'b0, -1, -1, 260);
        chk("na_reads", n_rd, 128);
        chk("na_writes", n_wr, 128);
        chk("na_lat", first_wr - first_rd, 24);
        chk("na_first_addr", first_wr_addr, 'h40);
        chk("na_last_addr", last_wr_addr, 'h3F);
        chk("na_addr_seq", rd_err + wr_err, 0);
        chk("na_done_cnt", n_done, 1);
        chk("na_done_lag", done_cyc - last_wr_cyc, 1);
        chk("na_busy_done", busy_at_done, 0);
        chk("na_no_wrd", n_w, 0);
        chk("na_pattern", pat_err, 0);

        op(1'b1, 7'h00, 7'h40, 1'b0, -1, -1, 260);
        chk("ac_w_lat", first_w - first_rd, 16);
        chk("ac_wr_lat", first_wr - first_rd, 25);
        chk("ac_writes", n_wr, 128);
        chk("ac_wreads", n_w, 128);
        chk("ac_addr_seq", rd_err + wr_err + w_err, 0);
        chk("ac_acc_held", acc_err, 0);
        chk("ac_done_cnt", n_done, 1);

        op(1'b0, 7'h7E, 7'h10, 1'b1, -1, -1, 260);
        chk("bb_reads", n_rd, 128);
        chk("bb_writes", n_wr, 128);
        chk("bb_addr_seq", rd_err + wr_err, 0);
        chk("bb_pattern", pat_err, 0);
        chk("bb_last_addr", last_wr_addr, 'h0F);
        chk("bb_done_cnt", n_done, 1);
`ifdef NTT_MASKED_PWM_SEQ_STATS_EN
        chk("bb_stall_cnt", int'(stall_cnt), 42);
`endif

        op(1'b0, 7'h05, 7'h20, 1'b0, 60, -1, 120);
        chk("zz_busy", int'(busy), 0);
        chk("zz_reads", n_rd, 60);
        chk("zz_writes", n_wr, 36);
        chk("zz_done_cnt", n_done, 0);

        op(1'b0, 7'h00, 7'h00, 1'b0, -1, 10, 260);
        chk("sb_done_cnt", n_done, 1);
        chk("sb_reads", n_rd, 128);
        chk("sb_writes", n_wr, 128);
        chk("sb_last_addr", last_wr_addr, 'h7F);

        op(1'b1, 7'h11, 7'h22, 1'b0, -1, -1, 140);
        chk("rd_busy_pre", int'(busy), 1);
        chk("rd_wr_pre", int'(wr_en), 1);
        #2 reset = 1'b1;
        #1;
        chk("rd_rd_en", int'(rd_en), 0);
        chk("rd_wr_en", int'(wr_en), 0);
        chk("rd_w_rd_en", int'(w_rd_en), 0);
        chk("rd_busy", int'(busy), 0);
        chk("rd_done", int'(done), 0);
        chk("rd_acc", int'(accumulate), 0);
        chk("rd_addrs", int'(wr_addr) + int'(rd_addr) + int'(w_rd_addr), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        op(1'b0, 7'h03, 7'h30, 1'b0, -1, -1, 260);
        chk("rr_done_cnt", n_done, 1);
        chk("rr_writes", n_wr, 128);
        chk("rr_addr_seq", rd_err + wr_err, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1);
    end

endmodule
